// File: rtl/smiley_wall_collision_if.sv
// Pixel-rate bundle between the smiley/wall integrator and the collision unit.
// Suffixes are relative to the collision unit (slave side).
interface smiley_wall_collision_if #(
    parameter int PIX_CNT_W = 12,
    parameter int TOTAL_W   = 8
);
    logic                 startOfFrame_i;
    logic                 smileyDR_i;
    logic [2:0]           smileyHitEdgeCode_i;
    logic                 wallDR_i;
    logic                 totalClear_i;
    logic                 collision_o;
    logic [4:0]           edgeMask_o;
    logic [PIX_CNT_W-1:0] overlapPixels_o;
    logic [TOTAL_W-1:0]   collisionsTotal_o;
    logic                 inCooldown_o;

    modport master (
        output startOfFrame_i, smileyDR_i, smileyHitEdgeCode_i,
        output wallDR_i, totalClear_i,
        input  collision_o, edgeMask_o, overlapPixels_o,
        input  collisionsTotal_o, inCooldown_o
    );

    modport slave (
        input  startOfFrame_i, smileyDR_i, smileyHitEdgeCode_i,
        input  wallDR_i, totalClear_i,
        output collision_o, edgeMask_o, overlapPixels_o,
        output collisionsTotal_o, inCooldown_o
    );
endinterface

// File: rtl/smiley_wall_collision.sv
// Per-frame smiley/wall overlap accumulator with once-per-frame reporting
// and a cooldown so a single bounce yields a single collision event.
module smiley_wall_collision #(
    parameter int COOLDOWN_FRAMES = 2,
    parameter int PIX_CNT_W       = 12,
    parameter int TOTAL_W         = 8
) (
    input  logic clk,
    input  logic resetN,
    smiley_wall_collision_if.slave bus
);
    localparam int CD_W = (COOLDOWN_FRAMES > 0) ?
                          $clog2(COOLDOWN_FRAMES + 1) : 1;

    typedef enum logic {
        ACCUM    = 1'b0,
        COOLDOWN = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [CD_W-1:0]      cd_q, cd_d;
    logic                 frame_hit_q, frame_hit_d;
    logic [4:0]           edge_acc_q, edge_acc_d;
    logic [PIX_CNT_W-1:0] pix_q, pix_d;
    logic                 col_q, col_d;
    logic [4:0]           mask_q, mask_d;
    logic [PIX_CNT_W-1:0] ovl_q, ovl_d;
    logic [TOTAL_W-1:0]   tot_q, tot_d;

    logic       hit;
    logic       sof;
    logic       report;
    logic [4:0] code_oh;

    assign hit = bus.smileyDR_i & bus.wallDR_i;
    assign sof = bus.startOfFrame_i;

    // Codes 5-7 are valid hits that simply carry no edge information.
    always_comb begin
        code_oh = '0;
        if (bus.smileyHitEdgeCode_i < 3'd5)
            code_oh = 5'b00001 << bus.smileyHitEdgeCode_i;
    end

    always_comb begin
        state_d     = state_q;
        cd_d        = cd_q;
        frame_hit_d = frame_hit_q;
        edge_acc_d  = edge_acc_q;
        pix_d       = pix_q;
        col_d       = 1'b0;
        mask_d      = mask_q;
        ovl_d       = ovl_q;
        tot_d       = tot_q;
        report      = 1'b0;

        if (sof) begin
            frame_hit_d = hit;
            edge_acc_d  = hit ? code_oh : 5'b0;
            pix_d       = hit ? PIX_CNT_W'(1) : '0;
        end else if (hit) begin
            frame_hit_d = 1'b1;
            edge_acc_d  = edge_acc_q | code_oh;
            if (pix_q != '1)
                pix_d = pix_q + PIX_CNT_W'(1);
        end

        if (sof) begin
            unique case (state_q)
                ACCUM: begin
                    if (frame_hit_q) begin
                        col_d  = 1'b1;
                        mask_d = edge_acc_q;
                        ovl_d  = pix_q;
                        report = 1'b1;
                        if (COOLDOWN_FRAMES > 0) begin
                            cd_d    = CD_W'(COOLDOWN_FRAMES);
                            state_d = COOLDOWN;
                        end
                    end
                end
                COOLDOWN: begin
                    cd_d = cd_q - CD_W'(1);
                    if (cd_q == CD_W'(1))
                        state_d = ACCUM;
                end
                default: state_d = ACCUM;
            endcase
        end

        // A clear coinciding with a report wins.
        if (bus.totalClear_i)
            tot_d = '0;
        else if (report && (tot_q != '1))
            tot_d = tot_q + TOTAL_W'(1);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= ACCUM;
            cd_q        <= '0;
            frame_hit_q <= 1'b0;
            edge_acc_q  <= '0;
            pix_q       <= '0;
            col_q       <= 1'b0;
            mask_q      <= '0;
            ovl_q       <= '0;
            tot_q       <= '0;
        end else begin
            state_q     <= state_d;
            cd_q        <= cd_d;
            frame_hit_q <= frame_hit_d;
            edge_acc_q  <= edge_acc_d;
            pix_q       <= pix_d;
            col_q       <= col_d;
            mask_q      <= mask_d;
            ovl_q       <= ovl_d;
            tot_q       <= tot_d;
        end
    end

    assign bus.collision_o       = col_q;
    assign bus.edgeMask_o        = mask_q;
    assign bus.overlapPixels_o   = ovl_q;
    assign bus.collisionsTotal_o = tot_q;
    assign bus.inCooldown_o      = (state_q == COOLDOWN);
endmodule

// File: tb/tb_smiley_wall_collision.sv
// Randomised and directed bench for smiley_wall_collision against a
// frame-level behavioural model.
module tb_smiley_wall_collision;
    localparam int CD   = 2;
    localparam int PW   = 4;
    localparam int TW   = 3;
    localparam int PMAX = 15;
    localparam int TMAX = 7;

    logic clk;
    logic resetN;
    bit   run_cmp;
    int   n_pass;
    int   n_total;

    smiley_wall_collision_if #(.PIX_CNT_W(PW), .TOTAL_W(TW)) bus ();

    smiley_wall_collision #(
        .COOLDOWN_FRAMES(CD),
        .PIX_CNT_W(PW),
        .TOTAL_W(TW)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .bus(bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state: raw counts per frame, suppression as frames remaining.
    int       m_cnt;
    bit       m_hitf;
    bit [4:0] m_edge;
    int       m_supp;
    bit       m_col;
    bit [4:0] m_em;
    int       m_op;
    int       m_tot;
    bit       m_incd;

    task automatic chk(input string nm, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    function automatic bit [4:0] edge_bit(input int code);
        bit [4:0] r;
        r = 5'b0;
        if (code < 5) r[code] = 1'b1;
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge resetN);
            if (!resetN) begin
                m_cnt = 0; m_hitf = 0; m_edge = 0; m_supp = 0;
                m_col = 0; m_em = 0; m_op = 0; m_tot = 0; m_incd = 0;
            end else begin
                bit h;
                bit rep;
                int code;
                h    = bus.smileyDR_i && bus.wallDR_i;
                code = int'(bus.smileyHitEdgeCode_i);
                rep  = 0;
                m_col = 0;
                if (bus.startOfFrame_i) begin
                    if (m_supp > 0) m_supp--;
                    else if (m_hitf) begin
                        rep    = 1;
                        m_col  = 1;
                        m_em   = m_edge;
                        m_op   = (m_cnt > PMAX) ? PMAX : m_cnt;
                        m_supp = CD;
                    end
                    m_hitf = h;
                    m_cnt  = h ? 1 : 0;
                    m_edge = h ? edge_bit(code) : 5'b0;
                end else if (h) begin
                    m_hitf = 1;
                    if (m_cnt < 1000) m_cnt++;
                    m_edge |= edge_bit(code);
                end
                if (bus.totalClear_i) m_tot = 0;
                else if (rep && m_tot < TMAX) m_tot++;
                m_incd = (m_supp > 0);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (run_cmp) begin
                chk("collision", int'(bus.collision_o), int'(m_col));
                chk("edgeMask", int'(bus.edgeMask_o), int'(m_em));
                chk("overlapPixels", int'(bus.overlapPixels_o), m_op);
                chk("collisionsTotal", int'(bus.collisionsTotal_o), m_tot);
                chk("inCooldown", int'(bus.inCooldown_o), int'(m_incd));
            end
        end
    end

    task automatic px(input bit sof, input bit sdr, input int code,
                      input bit wdr, input bit clr);
        bus.startOfFrame_i      = sof;
        bus.smileyDR_i          = sdr;
        bus.smileyHitEdgeCode_i = 3'(code);
        bus.wallDR_i            = wdr;
        bus.totalClear_i        = clr;
        @(posedge clk);
        #2;
    endtask

    task automatic hits(input int n, input int code);
        repeat (n) px(0, 1, code, 1, 0);
    endtask

    task automatic quiet(input int n);
        repeat (n) px(0, 1'($urandom_range(0, 1)), $urandom_range(0, 7), 0, 0);
    endtask

    task automatic sof_quiet();
        px(1, 0, 0, 1, 0);
    endtask

    task automatic lit(input int col, input int em, input int op,
                       input int tot, input int incd);
        chk("lit_collision", int'(bus.collision_o), col);
        chk("lit_edgeMask", int'(bus.edgeMask_o), em);
        chk("lit_overlap", int'(bus.overlapPixels_o), op);
        chk("lit_total", int'(bus.collisionsTotal_o), tot);
        chk("lit_inCooldown", int'(bus.inCooldown_o), incd);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        run_cmp = 0;
        resetN  = 1'b0;
        bus.startOfFrame_i      = 1'b0;
        bus.smileyDR_i          = 1'b0;
        bus.smileyHitEdgeCode_i = 3'd0;
        bus.wallDR_i            = 1'b0;
        bus.totalClear_i        = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        lit(0, 0, 0, 0, 0);
        resetN  = 1'b1;
        run_cmp = 1;

        repeat (3) begin
            sof_quiet();
            quiet(20);
        end
        sof_quiet();
        lit(0, 0, 0, 0, 0);

        hits(10, 3);
        hits(4, 1);
        quiet(3);
        sof_quiet();
        lit(1, 5'b01010, 14, 1, 1);
        hits(2, 0);
        quiet(2);
        sof_quiet();
        lit(0, 5'b01010, 14, 1, 1);
        hits(2, 4);
        quiet(2);
        sof_quiet();
        lit(0, 5'b01010, 14, 1, 0);
        hits(3, 2);
        quiet(2);
        sof_quiet();
        lit(1, 5'b00100, 3, 2, 1);

        quiet(4);
        sof_quiet();
        quiet(4);
        px(1, 1, 0, 1, 0);
        quiet(5);
        sof_quiet();
        lit(1, 5'b00001, 1, 3, 1);

        quiet(3);
        sof_quiet();
        quiet(3);
        sof_quiet();
        hits(40, 6);
        sof_quiet();
        lit(1, 5'b00000, 15, 4, 1);

        quiet(3);
        resetN = 1'b0;
        #1;
        lit(0, 0, 0, 0, 0);
        @(posedge clk);
        #2;
        resetN = 1'b1;
        quiet(2);
        sof_quiet();
        hits(5, 4);
        sof_quiet();
        lit(1, 5'b10000, 5, 1, 1);
        quiet(2);
        sof_quiet();
        quiet(2);
        sof_quiet();
        hits(1, 1);
        px(1, 0, 0, 0, 1);
        lit(1, 5'b00010, 1, 0, 1);
        quiet(2);

        for (int f = 0; f < 40; f++) begin
            int dens;
            int len;
            dens = $urandom_range(0, 3);
            px(1, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
               1'(($urandom_range(0, 3) < dens) ? 1 : 0),
               1'(($urandom_range(0, 19) == 0) ? 1 : 0));
            len = $urandom_range(5, 30);
            for (int p = 0; p < len; p++) begin
                px(0, 1'($urandom_range(0, 1)), $urandom_range(0, 7),
                   1'(($urandom_range(0, 3) < dens) ? 1 : 0),
                   1'(($urandom_range(0, 49) == 0) ? 1 : 0));
            end
        end
        quiet(3);

        run_cmp = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/smiley_wall_collision.md
Name: smiley_wall_collision

Overview:
- Downstream consumer of the smiley bitmap stage. Takes the smiley drawingRequest and HitEdgeCode, plus the wall layer drawingRequest, on every pixel clock.
- Accumulates overlap information across one video frame and reports it once per frame at startOfFrame: a one-cycle collision pulse, the set of smiley edges that touched, and the overlap pixel count.
- Includes a cooldown state machine so the mover sees a single collision event per bounce.

Parameters:
- COOLDOWN_FRAMES, 2: frames during which new collisions are suppressed after a reported one; 0 disables cooldown.
- PIX_CNT_W, 12: width of the saturating overlap-pixel counter.
- TOTAL_W, 8: width of the saturating lifetime collision counter.

Ports:
- clk, in, 1: pixel clock.
- resetN, in, 1: asynchronous, active-low reset.
- startOfFrame, in, 1: one-cycle pulse marking the first pixel of a frame.
- smileyDR, in, 1: smiley drawingRequest, registered by the bitmap stage.
- smileyHitEdgeCode, in, 3: smiley HitEdgeCode, same-cycle aligned with smileyDR.
- wallDR, in, 1: wall layer drawingRequest, already aligned to smileyDR by the integrator.
- totalClear, in, 1: synchronous clear of collisionsTotal.
- collision, out, 1: one-cycle pulse reporting a collision in the previous frame.
- edgeMask, out, 5: one-hot OR of edges touched in the reported frame; held until the next report.
- overlapPixels, out, PIX_CNT_W: overlap pixel count of the reported frame; held until the next report.
- collisionsTotal, out, TOTAL_W: saturating count of reported collisions.
- inCooldown, out, 1: high while in the COOLDOWN state.

Behaviour:
- Reset (async, resetN=0):
  - state=ACCUM.
  - All accumulators and cooldown counter cleared.
  - collision=0, edgeMask=0, overlapPixels=0, collisionsTotal=0, inCooldown=0.
- Overlap condition: hit = smileyDR & wallDR, sampled every clock.
- Edge code to mask bit: code 0 (bottom) sets bit0; 1 (left) sets bit1; 2 (right) sets bit2; 3 (top) sets bit3; 4 (corner/diagonal) sets bit4.
  - Codes 5-7 set no mask bit, but the pixel still counts as a hit.
- Per-frame accumulators, updated on each non-SOF cycle with hit=1:
  - frameHit <= 1.
  - edgeAcc |= onehot(code).
  - pixCnt <= pixCnt+1, saturating at all-ones.
- On a startOfFrame cycle:
  - Accumulators are re-initialised to the contribution of the SOF pixel itself: hit on that cycle counts toward the new frame, with pixCnt=1 and frameHit=1.
  - The previous frame's values are evaluated first, per the state machine below.
- collision defaults to 0 every cycle; it is never high for two consecutive cycles.
- State ACCUM, at SOF with frameHit=1:
  - collision<=1, edgeMask<=edgeAcc, overlapPixels<=pixCnt.
  - collisionsTotal increments, saturating.
  - If COOLDOWN_FRAMES>0: cdCnt<=COOLDOWN_FRAMES and state->COOLDOWN. Otherwise stay in ACCUM.
- State ACCUM, at SOF with frameHit=0: no report; edgeMask and overlapPixels are held.
- State COOLDOWN, at each SOF:
  - No report, regardless of frameHit.
  - cdCnt decrements; if cdCnt==1 before the decrement, state->ACCUM.
  - The frame that begins at that SOF is therefore eligible for reporting.
- inCooldown = (state==COOLDOWN), registered.
- totalClear:
  - Clears collisionsTotal on the next edge.
  - If it coincides with an increment, the clear wins and the result is 0.
- Latency: collision, edgeMask and overlapPixels update on the clock edge where startOfFrame=1 is sampled, i.e. visible one cycle after the SOF pulse.
- Width rule: pixCnt saturates at 2^PIX_CNT_W-1 and collisionsTotal at 2^TOTAL_W-1; neither wraps.
- Without startOfFrame, accumulation continues indefinitely (saturating) and no report is produced.
- Asynchronous reset mid-frame or mid-cooldown discards all accumulated data and returns to ACCUM.

Test Plan:
- Reset, then 3 frames with no overlap -> collision never asserts; edgeMask=0, overlapPixels=0, collisionsTotal=0.
- Frame 1: 10 overlap pixels with code 3, then 4 with code 1; next SOF -> single collision pulse, edgeMask=5'b01010, overlapPixels=14, collisionsTotal=1, inCooldown=1.
- With COOLDOWN_FRAMES=2, overlap in each of frames 2, 3 and 4 -> no pulse at SOF2 or SOF3; inCooldown drops after SOF3; pulse at SOF4 reporting frame 4; collisionsTotal=2.
- Overlap on the SOF cycle itself with code 0, no other hits in that frame -> next SOF reports edgeMask=5'b00001, overlapPixels=1.
- PIX_CNT_W=4 with 40 overlap pixels in one frame -> overlapPixels=15; code 6 pixels only -> collision=1, edgeMask=0.
- Assert resetN=0 during cooldown -> outputs zero immediately, state ACCUM; the next frame with overlap reports normally. totalClear pulsed together with a report -> collisionsTotal=0.
